truth_table_sweeper: RTL and testbench
======================================

Name: truth_table_sweeper

Overview:
- Sequential stimulus/capture engine for combinational gate-level circuits such as minimized 5-input SOP/POS functions.
- Drives every input combination onto a device-under-exercise (DUE), waits a settle window, samples the single-bit output, and assembles the full truth table.
- Compares the captured table against an expected minterm mask and reports pass/fail, mismatch count and first failing index.
- Sits beside the combinational exercise circuits, on the board or in the bench wrapper, as their driver/checker.

Parameters:
- N_IN, 5, number of DUE inputs; vector index bit N_IN-1 maps to input A (MSB) and bit 0 to the last input (E for N_IN=5).
- SETTLE, 2, extra cycles each vector is held before f_in is sampled (0 is legal).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin a sweep; honoured only in IDLE.
- exp_tt  input  2**N_IN  expected truth table; bit i is the expected F for vector i. Sampled on the accepted start cycle.
- stop_on_fail  input  1  sampled on the accepted start cycle; 1 ends the sweep after the first mismatch.
- f_in  input  1  DUE output.
- vec_out  output  N_IN  vector currently driven to the DUE inputs; registered.
- busy  output  1  high from the cycle after an accepted start until the cycle done pulses.
- done  output  1  one-cycle pulse when results are final.
- pass  output  1  1 when the sweep completed with zero mismatches; valid from done until the next accepted start.
- tt_out  output  2**N_IN  captured truth table; unvisited bits are 0.
- fail_cnt  output  N_IN+1  number of mismatching vectors.
- first_fail_idx  output  N_IN  lowest mismatching index; 0 when fail_cnt==0.

Behaviour:
- Reset values: vec_out=0, busy=0, done=0, pass=0, tt_out=0, fail_cnt=0, first_fail_idx=0. FSM goes to IDLE.
- Reset mid-sweep: everything returns to reset values on the next edge. No done pulse is produced.
- States are IDLE, HOLD, SAMPLE, FINISH.
- IDLE to HOLD on start:
  - latches exp_tt and stop_on_fail;
  - clears tt_out, fail_cnt, first_fail_idx and pass;
  - sets vec_out=0, settle counter=0, busy=1.
- HOLD: vec_out is stable; the counter increments each cycle. Go to SAMPLE when counter==SETTLE; with SETTLE=0 the FSM goes straight to SAMPLE.
- SAMPLE: one cycle.
  - Writes tt_out[vec_out]=f_in.
  - On mismatch with the latched exp bit: fail_cnt+1, and first_fail_idx=vec_out if this is the first mismatch.
  - Next state:
    - if vec_out == 2**N_IN-1, or (stop_on_fail and a mismatch occurred now), go to FINISH;
    - otherwise vec_out+1, counter=0, go to HOLD.
- Cycles per vector = SETTLE+2. A full sweep for N_IN=5, SETTLE=2 is 128 cycles from the start edge to the FINISH entry.
- FINISH: one cycle.
  - pass = (fail_cnt==0) and the sweep covered all vectors.
  - done=1, busy drops to 0 in the same cycle, then return to IDLE.
- vec_out holds its final value in IDLE. Results hold until the next accepted start.
- start while busy or in FINISH is ignored, with no restart and no queueing.
- start in the same cycle as rst: reset wins.
- No wrap-around: the vector counter never increments past 2**N_IN-1.
- fail_cnt cannot overflow; its maximum is 2**N_IN.

Test Plan:
- Correct DUE: f_in = (A|B)&(C|D)&E from vec_out, exp_tt=32'hA8A8A800, start -> done after 128 cycles; tt_out=32'hA8A8A800, pass=1, fail_cnt=0, first_fail_idx=0.
- Faulty DUE: f_in = (A|B)&(C|D), E ignored, same exp_tt, stop_on_fail=0 -> tt_out=32'hFCFCFC00, fail_cnt=9, first_fail_idx=10, pass=0.
- Stop on fail: same faulty DUE, stop_on_fail=1 -> done after 11 vectors (44 cycles); vec_out=10, fail_cnt=1, tt_out=32'h00000400, pass=0.
- Settle timing: SETTLE=0 with correct DUE -> 64-cycle sweep. Check vec_out changes exactly every 2 cycles and the sample is taken on the SAMPLE cycle.
- Start while busy: pulse start at cycle 20 of a sweep -> ignored; a single done, results identical to scenario 1.
- Reset mid-sweep: assert rst at vector 7 -> next cycle all outputs are 0 and there is no done. A later start performs a full clean sweep with pass=1.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
//
// Purpose:
//   Stimulus/capture engine for small combinational circuits (for example a
//   minimised 5-input SOP/POS function). It walks every input combination
//   onto the device under exercise (DUE) and holds each vector for a settle
//   window. It samples the DUE output once per vector and builds the full
//   truth table, comparing each sample against an expected minterm mask.
//   At the end it reports pass/fail, the number of mismatching vectors and
//   the lowest mismatching vector index.
//
// Parameters:
//   N_IN    number of DUE inputs. Vector bit N_IN-1 drives input A (MSB) and
//           bit 0 drives the last input.
//   SETTLE  extra cycles each vector is held before f_in is sampled (0 legal).
//
// Ports:
//   clk             system clock, rising edge
//   rst             synchronous active-high reset
//   start           one-cycle sweep request, honoured only while idle
//   exp_tt          expected truth table (bit i = expected F for vector i),
//                   captured when a start is accepted
//   stop_on_fail    captured with start; 1 ends the sweep at the first mismatch
//   f_in            DUE output
//   vec_out         registered vector currently driven onto the DUE inputs
//   busy            high while a sweep is in progress
//   done            one-cycle pulse when the results are final
//   pass            full sweep with zero mismatches; valid from done onwards
//   tt_out          captured truth table, bits never visited read as 0
//   fail_cnt        number of mismatching vectors (max 2**N_IN)
//   first_fail_idx  lowest mismatching vector index, 0 if there was none

module truth_table_sweeper #(
  parameter int N_IN   = 5,
  parameter int SETTLE = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [(2**N_IN)-1:0]   exp_tt,
  input  logic                   stop_on_fail,
  input  logic                   f_in,
  output logic [N_IN-1:0]        vec_out,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [(2**N_IN)-1:0]   tt_out,
  output logic [N_IN:0]          fail_cnt,
  output logic [N_IN-1:0]        first_fail_idx
);

  localparam int TT_W  = 2**N_IN;
  // The settle counter must reach SETTLE and the value one past it without
  // wrapping, hence SETTLE+2 distinct codes.
  localparam int CNT_W = $clog2(SETTLE + 2);

  localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [N_IN-1:0]  LAST_VEC = {N_IN{1'b1}};
  localparam logic [N_IN-1:0]  VEC_ONE  = N_IN'(1);
  localparam logic [N_IN:0]    FAIL_ONE = (N_IN + 1)'(1);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    SAMPLE,
    FINISH
  } state_t;

  state_t state;
  state_t state_nx;

  logic [TT_W-1:0]  exp_q;
  logic             stop_q;
  logic [CNT_W-1:0] settle_cnt;
  logic             exp_bit;
  logic             mismatch;
  logic             last_vec;

  // Expected bit for the vector on the DUE pins, and whether the sample
  // taken this cycle disagrees with it. Only meaningful in SAMPLE.
  always_comb begin
    exp_bit  = exp_q[vec_out];
    last_vec = (vec_out == LAST_VEC);
    mismatch = (state == SAMPLE) && (f_in != exp_bit);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic. A start outside IDLE is dropped, not queued.
  // The sweep ends early only on a mismatch with stop_on_fail latched.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = HOLD;
        end
      end
      HOLD: begin
        if (settle_cnt == SETTLE_C) begin
          state_nx = SAMPLE;
        end
      end
      SAMPLE: begin
        if (last_vec || (stop_q && mismatch)) begin
          state_nx = FINISH;
        end else begin
          state_nx = HOLD;
        end
      end
      FINISH: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Datapath. Results are cleared only when a new sweep is accepted. They
  // therefore hold through FINISH and IDLE until the next start.
  // pass is resolved on the SAMPLE->FINISH edge so that it is already valid
  // in the cycle done is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q          <= '0;
      stop_q         <= 1'b0;
      settle_cnt     <= '0;
      vec_out        <= '0;
      tt_out         <= '0;
      fail_cnt       <= '0;
      first_fail_idx <= '0;
      pass           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            exp_q          <= exp_tt;
            stop_q         <= stop_on_fail;
            settle_cnt     <= '0;
            vec_out        <= '0;
            tt_out         <= '0;
            fail_cnt       <= '0;
            first_fail_idx <= '0;
            pass           <= 1'b0;
          end
        end
        HOLD: begin
          settle_cnt <= settle_cnt + CNT_ONE;
        end
        SAMPLE: begin
          tt_out[vec_out] <= f_in;
          if (mismatch) begin
            fail_cnt <= fail_cnt + FAIL_ONE;
            if (fail_cnt == '0) begin
              first_fail_idx <= vec_out;
            end
          end
          if (state_nx == HOLD) begin
            vec_out    <= vec_out + VEC_ONE;
            settle_cnt <= '0;
          end else begin
            // Covering every vector is required for a pass. An early stop
            // always carries a mismatch, so it can never pass.
            pass <= !mismatch && (fail_cnt == '0) && last_vec;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Status flags decode directly from the state register.
  always_comb begin
    busy = (state == HOLD) || (state == SAMPLE);
    done = (state == FINISH);
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper
//
// Bench for truth_table_sweeper. Two instances share all control inputs:
// dut_a uses SETTLE=2 (4 cycles per vector) and dut_b uses SETTLE=0
// (2 cycles per vector). Each has its own DUE model on f_in. The DUE output
// is deliberately inverted on every cycle except the sampling cycle, so a
// capture taken at the wrong time shows up in the truth table. Expected
// results come from a plain loop over all input combinations.

module tb_truth_table_sweeper;

  localparam int N_IN = 5;
  localparam int TT_W = 32;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [TT_W-1:0] exp_tt;
  logic stop_on_fail;
  logic f_in_a;
  logic f_in_b;

  logic [N_IN-1:0] vec_a, vec_b;
  logic busy_a, busy_b, done_a, done_b, pass_a, pass_b;
  logic [TT_W-1:0] tt_a, tt_b;
  logic [N_IN:0] fc_a, fc_b;
  logic [N_IN-1:0] ff_a, ff_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  truth_table_sweeper #(.N_IN(N_IN), .SETTLE(2)) dut_a (
    .clk(clk), .rst(rst), .start(start), .exp_tt(exp_tt),
    .stop_on_fail(stop_on_fail), .f_in(f_in_a), .vec_out(vec_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .tt_out(tt_a),
    .fail_cnt(fc_a), .first_fail_idx(ff_a)
  );

  truth_table_sweeper #(.N_IN(N_IN), .SETTLE(0)) dut_b (
    .clk(clk), .rst(rst), .start(start), .exp_tt(exp_tt),
    .stop_on_fail(stop_on_fail), .f_in(f_in_b), .vec_out(vec_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .tt_out(tt_b),
    .fail_cnt(fc_b), .first_fail_idx(ff_b)
  );

  // DUE behaviours: 0 = (A|B)&(C|D)&E, 1 = (A|B)&(C|D) with E ignored,
  // anything else = arbitrary table rtt.
  function automatic logic due_bit(input int sel, input logic [TT_W-1:0] rtt,
                                   input logic [N_IN-1:0] v);
    logic a, b, c, d, e;
    {a, b, c, d, e} = v;
    case (sel)
      0:       return (a | b) & (c | d) & e;
      1:       return (a | b) & (c | d);
      default: return rtt[v];
    endcase
  endfunction

  // Reference sweep: visit vectors in order, record, count mismatches,
  // optionally stop at the first one.
  task automatic model(input int sel, input logic [TT_W-1:0] rtt,
                       input logic [TT_W-1:0] expv, input logic stop,
                       output logic [TT_W-1:0] tt, output int cnt,
                       output int first, output logic pass, output int nvec);
    tt = '0; cnt = 0; first = 0; nvec = 0;
    for (int v = 0; v < TT_W; v++) begin
      logic b;
      b = due_bit(sel, rtt, N_IN'(v));
      nvec++;
      tt[v] = b;
      if (b !== expv[v]) begin
        if (cnt == 0) first = v;
        cnt++;
        if (stop) break;
      end
    end
    pass = (cnt == 0) && (nvec == TT_W);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "/a_vec"},   64'(vec_a),  64'd0);
    checkOutput({tag, "/a_busy"},  64'(busy_a), 64'd0);
    checkOutput({tag, "/a_done"},  64'(done_a), 64'd0);
    checkOutput({tag, "/a_pass"},  64'(pass_a), 64'd0);
    checkOutput({tag, "/a_tt"},    64'(tt_a),   64'd0);
    checkOutput({tag, "/a_fcnt"},  64'(fc_a),   64'd0);
    checkOutput({tag, "/a_first"}, 64'(ff_a),   64'd0);
    checkOutput({tag, "/b_vec"},   64'(vec_b),  64'd0);
    checkOutput({tag, "/b_busy"},  64'(busy_b), 64'd0);
    checkOutput({tag, "/b_tt"},    64'(tt_b),   64'd0);
    checkOutput({tag, "/b_fcnt"},  64'(fc_b),   64'd0);
  endtask

  // Runs one sweep on both instances. extra_start_c pulses start again that
  // many cycles after the accepted start edge. rst_c asserts reset at that
  // cycle instead of letting the sweep finish (-1 disables either).
  task automatic applyStimulus(input string tag, input int sel,
                               input logic [TT_W-1:0] rtt,
                               input logic [TT_W-1:0] expv, input logic stop,
                               input int extra_start_c, input int rst_c);
    logic [TT_W-1:0] m_tt;
    int m_cnt, m_first, m_nvec;
    logic m_pass;
    int ta, tb_, c;
    int done_a_c, done_b_c, ndone_a, ndone_b, bad_a, bad_b;

    model(sel, rtt, expv, stop, m_tt, m_cnt, m_first, m_pass, m_nvec);
    ta  = m_nvec * 4;
    tb_ = m_nvec * 2;

    @(negedge clk);
    exp_tt = expv; stop_on_fail = stop; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_tt = $urandom();
    stop_on_fail = ~stop;

    c = 0; done_a_c = -1; done_b_c = -1;
    ndone_a = 0; ndone_b = 0; bad_a = 0; bad_b = 0;
    while (1) begin
      if (done_a === 1'b1) begin ndone_a++; if (done_a_c < 0) done_a_c = c; end
      if (done_b === 1'b1) begin ndone_b++; if (done_b_c < 0) done_b_c = c; end
      if (rst_c < 0) begin
        if (c < ta) begin
          if (vec_a !== N_IN'(c / 4) || busy_a !== 1'b1 || done_a !== 1'b0) bad_a++;
        end else if (c == ta) begin
          if (busy_a !== 1'b0 || done_a !== 1'b1) bad_a++;
        end else if (busy_a !== 1'b0 || done_a !== 1'b0 || vec_a !== N_IN'(m_nvec - 1)) begin
          bad_a++;
        end
        if (c < tb_) begin
          if (vec_b !== N_IN'(c / 2) || busy_b !== 1'b1 || done_b !== 1'b0) bad_b++;
        end else if (c == tb_) begin
          if (busy_b !== 1'b0 || done_b !== 1'b1) bad_b++;
        end else if (busy_b !== 1'b0 || done_b !== 1'b0 || vec_b !== N_IN'(m_nvec - 1)) begin
          bad_b++;
        end
      end
      if (rst_c >= 0 && c == rst_c + 1) break;
      if (rst_c < 0 && c >= ta + 3) break;
      if (c >= 400) break;
      start  = (c == extra_start_c);
      rst    = (c == rst_c);
      f_in_a = due_bit(sel, rtt, vec_a) ^ ((c % 4) != 3);
      f_in_b = due_bit(sel, rtt, vec_b) ^ ((c % 2) != 1);
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    rst   = 1'b0;

    if (rst_c >= 0) begin
      checkAllZero({tag, "/after_rst"});
      repeat (12) begin
        @(negedge clk);
        if (done_a === 1'b1) ndone_a++;
        if (done_b === 1'b1) ndone_b++;
      end
      checkOutput({tag, "/a_no_done"}, 64'(ndone_a), 64'd0);
      checkOutput({tag, "/b_no_done"}, 64'(ndone_b), 64'd0);
    end else begin
      checkOutput({tag, "/a_done_cyc"}, 64'(done_a_c), 64'(ta));
      checkOutput({tag, "/a_ndone"},    64'(ndone_a),  64'd1);
      checkOutput({tag, "/a_trace"},    64'(bad_a),    64'd0);
      checkOutput({tag, "/a_tt"},       64'(tt_a),     64'(m_tt));
      checkOutput({tag, "/a_fcnt"},     64'(fc_a),     64'(m_cnt));
      checkOutput({tag, "/a_first"},    64'(ff_a),     64'(m_first));
      checkOutput({tag, "/a_pass"},     64'(pass_a),   64'(m_pass));
      checkOutput({tag, "/b_done_cyc"}, 64'(done_b_c), 64'(tb_));
      checkOutput({tag, "/b_ndone"},    64'(ndone_b),  64'd1);
      checkOutput({tag, "/b_trace"},    64'(bad_b),    64'd0);
      checkOutput({tag, "/b_tt"},       64'(tt_b),     64'(m_tt));
      checkOutput({tag, "/b_fcnt"},     64'(fc_b),     64'(m_cnt));
      checkOutput({tag, "/b_first"},    64'(ff_b),     64'(m_first));
      checkOutput({tag, "/b_pass"},     64'(pass_b),   64'(m_pass));
    end
  endtask

  initial begin
    logic [TT_W-1:0] rtt, expv;
    logic stop;

    rst = 1'b1; start = 1'b1; exp_tt = '1; stop_on_fail = 1'b0;
    f_in_a = 1'b0; f_in_b = 1'b0;
    repeat (3) @(negedge clk);
    checkAllZero("reset_with_start");
    rst = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);
    checkAllZero("idle_after_reset");

    $display("[TB] correct DUE, full sweep");
    applyStimulus("correct", 0, '0, 32'hA8A8A800, 1'b0, -1, -1);
    checkOutput("correct/a_tt_const", 64'(tt_a), 64'h00000000A8A8A800);
    checkOutput("correct/a_pass_const", 64'(pass_a), 64'd1);

    $display("[TB] faulty DUE, no stop");
    applyStimulus("faulty", 1, '0, 32'hA8A8A800, 1'b0, -1, -1);
    checkOutput("faulty/a_tt_const", 64'(tt_a), 64'h00000000FCFCFC00);
    checkOutput("faulty/a_fcnt_const", 64'(fc_a), 64'd9);
    checkOutput("faulty/a_first_const", 64'(ff_a), 64'd10);

    $display("[TB] faulty DUE, stop on fail");
    applyStimulus("stopfail", 1, '0, 32'hA8A8A800, 1'b1, -1, -1);
    checkOutput("stopfail/a_vec_const", 64'(vec_a), 64'd10);
    checkOutput("stopfail/a_tt_const", 64'(tt_a), 64'h0000000000000400);

    $display("[TB] start while busy");
    applyStimulus("busystart", 0, '0, 32'hA8A8A800, 1'b0, 20, -1);

    $display("[TB] reset mid-sweep then clean sweep");
    applyStimulus("midrst", 0, '0, 32'hA8A8A800, 1'b0, -1, 29);
    applyStimulus("after_rst", 0, '0, 32'hA8A8A800, 1'b0, -1, -1);

    $display("[TB] boundaries: mismatch on last vector, all mismatching");
    applyStimulus("lastvec", 0, '0, 32'hA8A8A800 ^ 32'h80000000, 1'b1, -1, -1);
    applyStimulus("allbad", 0, '0, ~32'hA8A8A800, 1'b0, -1, -1);

    $display("[TB] randomized tables");
    for (int i = 0; i < 6; i++) begin
      rtt = $urandom();
      case (i % 3)
        0:       expv = rtt;
        1:       expv = rtt ^ $urandom();
        default: expv = rtt ^ (32'h1 << $urandom_range(31, 0));
      endcase
      stop = 1'($urandom_range(1, 0));
      applyStimulus($sformatf("rand%0d", i), 2, rtt, expv, stop, -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
